write_vec_piso_loader: RTL and testbench
========================================

Name: write_vec_piso_loader

Overview:
- Write-direction counterpart of the vector readout path. Receives a serial byte stream from the UART receiver and assembles it into vector register bank A or B, selected by the current opcode.
- The held vectors drive the compute blocks and the readout mux directly.
- Sits between the UART RX core and the vector datapath. It fully owns the storage for vec_a and vec_b.

Parameters:
- WIDTH, 8, bits per vector element. Must be a multiple of 8.
- LENGTH, 1024, elements per vector. Must be ≥2.
- BPE (localparam), WIDTH/8, bytes per element.
- IDX_W (localparam), $clog2(LENGTH), element index width.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- op  input  8  current command opcode, compared against `writeVec_A / `writeVec_B from the shared defines header.
- rx_data  input  8  received byte.
- rx_ready  input  1  one-cycle pulse, rx_data valid.
- vec_a  output  WIDTH x LENGTH  stored vector A.
- vec_b  output  WIDTH x LENGTH  stored vector B.
- busy  output  1  high while in LOAD.
- load_done  output  1  one-cycle pulse after the last byte is stored.
- load_abort  output  1  one-cycle pulse when a load is cancelled.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all counters 0.
  - Every element of vec_a and vec_b = 0.
  - busy, load_done, load_abort = 0.
- Reset asserted mid-load: identical result. Any partial data is discarded, including data already written.
- FSM states: IDLE, LOAD, DONE.
  - IDLE → LOAD:
    - Condition: op==`writeVec_A or op==`writeVec_B.
    - Latch target (0=A, 1=B); clear elem_idx and byte_idx.
    - busy goes high the next cycle.
    - rx_ready in IDLE is ignored, including in the transition cycle.
  - LOAD, each rx_ready:
    - rx_data is written into byte lane byte_idx of vec_target[elem_idx], bits [8*byte_idx+7 : 8*byte_idx]. Little-endian: the first byte of an element is its LSB.
    - byte_idx increments. At BPE-1 it wraps to 0 and elem_idx increments.
    - Only the addressed lane changes; all other elements hold.
  - LOAD → DONE:
    - Triggered by the rx_ready carrying the final byte (elem_idx=LENGTH-1, byte_idx=BPE-1). That byte is stored in the same edge.
    - load_done = 1 for exactly the next cycle. busy drops in that same cycle.
  - LOAD → IDLE (abort):
    - Triggered when op leaves both write codes before completion. load_abort pulses for one cycle.
    - Already-written elements keep their new values; unwritten elements keep their old values.
    - If rx_ready coincides with the op change, that byte is discarded (abort wins).
    - An op switch directly from `writeVec_A to `writeVec_B also aborts; the load then re-arms from IDLE on the following cycle.
  - DONE → IDLE:
    - Only after op is no longer a write code. This prevents re-triggering while the host still holds the opcode.
    - rx_ready in DONE is ignored.
- Registers:
  - vec_a and vec_b change only via writes in LOAD or via reset.
  - Both vectors are registered outputs with no combinational path from rx_data.
  - The non-target vector is never modified.
- Latency: a byte is visible on the vector output 1 cycle after its rx_ready edge.
- Back-to-back rx_ready on consecutive cycles must be accepted without loss.

Test Plan (LENGTH=4 unless stated):
- Reset → vec_a and vec_b all 0; busy, load_done, load_abort = 0. Then assert rst_n=0 mid-load → same all-zero state immediately, without a clock edge.
- op=`writeVec_A; send 0x11,0x22,0x33,0x44 with gaps → vec_a = {0x44,0x33,0x22,0x11} (index 3..0), vec_b unchanged at 0, load_done pulses once, busy low. Holding op keeps the block in DONE; sending 0x55 causes no change.
- op=`writeVec_B; send 0xA0..0xA3 on consecutive cycles → vec_b[i]=0xA0+i, vec_a retained.
- op=`writeVec_A; send 0x01,0x02; set op=0 in the same cycle as 0x03 → load_abort pulses, vec_a[0]=0x01, vec_a[1]=0x02, and vec_a[2], vec_a[3] keep their prior values.
- rx_ready pulses while op=0 → no vector change, busy stays 0.
- WIDTH=16, LENGTH=2, op=`writeVec_A; bytes 0x34,0x12,0x78,0x56 → vec_a[0]=0x1234, vec_a[1]=0x5678, load_done pulses once.

Source files
------------

// File: rtl/write_vec_piso_loader.sv
// Byte-serial loader for vector register banks A and B: assembles UART RX bytes
// little-endian into the bank selected by the write opcode and holds both vectors.
`ifndef writeVec_A
`define writeVec_A 8'h0A
`endif
`ifndef writeVec_B
`define writeVec_B 8'h0B
`endif

module write_vec_piso_loader #(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    op,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_ready,
    output logic [LENGTH-1:0][WIDTH-1:0]  vec_a,
    output logic [LENGTH-1:0][WIDTH-1:0]  vec_b,
    output logic                          busy,
    output logic                          load_done,
    output logic                          load_abort
);

    localparam int BPE   = WIDTH / 8;
    localparam int IDX_W = $clog2(LENGTH);
    localparam int BI_W  = (BPE > 1) ? $clog2(BPE) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic             tgt_b;
    logic [IDX_W-1:0] elem_idx;
    logic [BI_W-1:0]  byte_idx;

    logic op_is_a;
    logic op_is_b;
    logic op_is_wr;
    logic op_matches;
    logic wr_en;
    logic last_byte;
    logic last_lane;

    always_comb begin
        op_is_a    = (op == `writeVec_A);
        op_is_b    = (op == `writeVec_B);
        op_is_wr   = op_is_a | op_is_b;
        op_matches = tgt_b ? op_is_b : op_is_a;
        // An opcode change wins over a coincident byte, so the write is gated by op_matches.
        wr_en      = (state == LOAD) && op_matches && rx_ready;
        last_lane  = (byte_idx == BI_W'(BPE - 1));
        last_byte  = last_lane && (elem_idx == IDX_W'(LENGTH - 1));
    end

    assign busy = (state == LOAD);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tgt_b      <= 1'b0;
            elem_idx   <= '0;
            byte_idx   <= '0;
            load_done  <= 1'b0;
            load_abort <= 1'b0;
        end else begin
            load_done  <= 1'b0;
            load_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_is_wr) begin
                        state    <= LOAD;
                        tgt_b    <= op_is_b;
                        elem_idx <= '0;
                        byte_idx <= '0;
                    end
                end
                LOAD: begin
                    if (!op_matches) begin
                        state      <= IDLE;
                        load_abort <= 1'b1;
                    end else if (rx_ready) begin
                        if (last_lane) begin
                            byte_idx <= '0;
                            elem_idx <= elem_idx + 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                        if (last_byte) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!op_is_wr) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the vector banks are architecturally visible and must read zero after reset,
    // so unlike a plain RAM they are reset flops rather than an unreset memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_a <= '0;
            vec_b <= '0;
        end else if (wr_en) begin
            for (int l = 0; l < BPE; l++) begin
                if (byte_idx == BI_W'(l)) begin
                    if (tgt_b) vec_b[elem_idx][8*l +: 8] <= rx_data;
                    else       vec_a[elem_idx][8*l +: 8] <= rx_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_write_vec_piso_loader.sv
// Directed bench for write_vec_piso_loader: a byte-count model checked every cycle
// on a LENGTH=4 instance, plus literal checks on a WIDTH=16, LENGTH=2 instance.
`ifndef writeVec_A
`define writeVec_A 8'h0A
`endif
`ifndef writeVec_B
`define writeVec_B 8'h0B
`endif

module tb_write_vec_piso_loader;

    localparam int W = 8;
    localparam int L = 4;
    localparam int NBYTES = L * (W / 8);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0]            op, rx_data;
    logic                  rx_ready;
    logic [L-1:0][W-1:0]   vec_a, vec_b;
    logic                  busy, load_done, load_abort;

    logic [7:0]            op2, rx_data2;
    logic                  rx_ready2;
    logic [1:0][15:0]      vec_a2, vec_b2;
    logic                  busy2, load_done2, load_abort2;

    write_vec_piso_loader #(.WIDTH(W), .LENGTH(L)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .rx_data(rx_data), .rx_ready(rx_ready),
        .vec_a(vec_a), .vec_b(vec_b), .busy(busy), .load_done(load_done),
        .load_abort(load_abort)
    );

    write_vec_piso_loader #(.WIDTH(16), .LENGTH(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .op(op2), .rx_data(rx_data2), .rx_ready(rx_ready2),
        .vec_a(vec_a2), .vec_b(vec_b2), .busy(busy2), .load_done(load_done2),
        .load_abort(load_abort2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tracks how many bytes of the current load have arrived.
    typedef enum {M_IDLE, M_LOAD, M_DONE} mmode_t;
    mmode_t              m_mode;
    bit                  m_tgt_b;
    int                  m_count;
    logic [L-1:0][W-1:0] m_a, m_b;
    bit                  m_done, m_abort;
    int                  m_e, m_ln;

    function automatic bit is_wr(input logic [7:0] o);
        return (o == `writeVec_A) || (o == `writeVec_B);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  = M_IDLE;
            m_tgt_b = 1'b0;
            m_count = 0;
            m_a     = '0;
            m_b     = '0;
            m_done  = 1'b0;
            m_abort = 1'b0;
        end else begin
            m_done  = 1'b0;
            m_abort = 1'b0;
            case (m_mode)
                M_IDLE: if (is_wr(op)) begin
                    m_mode  = M_LOAD;
                    m_tgt_b = (op == `writeVec_B);
                    m_count = 0;
                end
                M_LOAD: begin
                    if (op != (m_tgt_b ? `writeVec_B : `writeVec_A)) begin
                        m_mode  = M_IDLE;
                        m_abort = 1'b1;
                    end else if (rx_ready) begin
                        m_e  = m_count / (W / 8);
                        m_ln = m_count % (W / 8);
                        if (m_tgt_b) m_b[m_e][8*m_ln +: 8] = rx_data;
                        else         m_a[m_e][8*m_ln +: 8] = rx_data;
                        m_count++;
                        if (m_count == NBYTES) begin
                            m_mode = M_DONE;
                            m_done = 1'b1;
                        end
                    end
                end
                M_DONE: if (!is_wr(op)) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        check("vec_a", 64'(vec_a), 64'(m_a));
        check("vec_b", 64'(vec_b), 64'(m_b));
        check("busy", 64'(busy), 64'(m_mode == M_LOAD));
        check("load_done", 64'(load_done), 64'(m_done));
        check("load_abort", 64'(load_abort), 64'(m_abort));
    end

    int done_cnt  = 0;
    int abort_cnt = 0;
    int done2_cnt = 0;
    always @(negedge clk) begin
        if (load_done  === 1'b1) done_cnt++;
        if (load_abort === 1'b1) abort_cnt++;
        if (load_done2 === 1'b1) done2_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        rx_data2  = b;
        rx_ready2 = 1'b1;
        step();
        rx_ready2 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; op = 8'h00; rx_data = 8'h00; rx_ready = 1'b0;
        op2 = 8'h00; rx_data2 = 8'h00; rx_ready2 = 1'b0;
        #1 rst_n = 1'b0;
        step(); step();
        check("rst vec_a", 64'(vec_a), 64'h0);
        check("rst vec_b", 64'(vec_b), 64'h0);
        check("rst flags", {61'h0, busy, load_done, load_abort}, 64'h0);
        rst_n = 1'b1;
        step();

        // Load A with gaps between bytes
        op = `writeVec_A;
        step();
        check("busy after arm", 64'(busy), 64'h1);
        done_cnt = 0;
        send(8'h11); step();
        send(8'h22); step();
        send(8'h33); step();
        send(8'h44);
        check("A vec_a", 64'(vec_a), 64'h44332211);
        check("A load_done", 64'(load_done), 64'h1);
        check("A busy low", 64'(busy), 64'h0);
        step();
        check("A done one cycle", 64'(load_done), 64'h0);
        send(8'h55); step();
        check("DONE ignores rx", 64'(vec_a), 64'h44332211);
        check("A vec_b untouched", 64'(vec_b), 64'h0);
        check("A done count", 64'(done_cnt), 64'h1);
        op = 8'h00;
        step(); step();

        // Load B back to back
        op = `writeVec_B;
        step();
        for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i));
        check("B vec_b", 64'(vec_b), 64'hA3A2A1A0);
        check("B vec_a kept", 64'(vec_a), 64'h44332211);
        op = 8'h00;
        step(); step();

        // Abort with a coincident byte
        op = `writeVec_A;
        step();
        abort_cnt = 0;
        send(8'h01);
        send(8'h02);
        rx_data = 8'h03; rx_ready = 1'b1; op = 8'h00;
        step();
        rx_ready = 1'b0;
        check("abort pulse", 64'(load_abort), 64'h1);
        check("abort vec_a", 64'(vec_a), 64'h44330201);
        step();
        check("abort one cycle", 64'(load_abort), 64'h0);
        check("abort count", 64'(abort_cnt), 64'h1);

        // A to B switch aborts, then re-arms on B
        op = `writeVec_A;
        step();
        send(8'h77);
        op = `writeVec_B;
        step();
        check("switch abort", 64'(load_abort), 64'h1);
        step();
        check("switch rearm busy", 64'(busy), 64'h1);
        send(8'hB7);
        op = 8'h00;
        step(); step();
        check("switch vec_a", 64'(vec_a), 64'h44330277);
        check("switch vec_b", 64'(vec_b), 64'hA3A2A1B7);

        // Bytes while idle are ignored
        send(8'h99); send(8'h98);
        check("idle vec_a", 64'(vec_a), 64'h44330277);
        check("idle busy", 64'(busy), 64'h0);

        // Asynchronous reset mid-load
        op = `writeVec_A;
        step();
        send(8'hEE);
        #1 rst_n = 1'b0;
        #1;
        check("async rst vec_a", 64'(vec_a), 64'h0);
        check("async rst vec_b", 64'(vec_b), 64'h0);
        check("async rst busy", 64'(busy), 64'h0);
        op = 8'h00;
        step();
        rst_n = 1'b1;
        step();

        // WIDTH=16, LENGTH=2 instance
        done2_cnt = 0;
        op2 = `writeVec_A;
        step();
        send2(8'h34); send2(8'h12); send2(8'h78); send2(8'h56);
        check("w16 vec_a", 64'(vec_a2), 64'h56781234);
        check("w16 load_done", 64'(load_done2), 64'h1);
        check("w16 busy", 64'(busy2), 64'h0);
        op2 = 8'h00;
        step(); step();
        check("w16 done count", 64'(done2_cnt), 64'h1);
        check("w16 vec_b", 64'(vec_b2), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
